// File: rtl/cpu_clk_ctrl.sv
// Programmable CPU clock generator with run/step/halt modes,
// debounced step button, heartbeat LEDs and a monitor nibble display.
module cpu_clk_ctrl #(
    parameter int CNT_WIDTH  = 32,
    parameter int DEB_CYCLES = 50000,
    parameter int NR_DIGIT   = 2,
    parameter int LED_WIDTH  = 8
) (
    input  logic                  clk50M,
    input  logic                  rst,
    input  logic [1:0]            mode,
    input  logic [CNT_WIDTH-1:0]  cpu_speed,
    input  logic                  step_btn,
    input  logic [31:0]           monitor_data,
    input  logic [2:0]            disp_sel,
    output logic                  clk_cpu,
    output logic                  cpu_running,
    output logic [31:0]           cpu_cycles,
    output logic [LED_WIDTH-1:0]  led_hb,
    output logic [4*NR_DIGIT-1:0] disp_data
);

    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
    localparam logic [DW-1:0] DEB_ONE = DW'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [1:0] MODE_RUN = 2'b00;
    localparam logic [1:0] MODE_STEP = 2'b01;
    localparam int DISP_W = 4 * NR_DIGIT;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_nxt;
    logic                 clk_nxt;
    logic                 pend_clr;
    logic                 tick;
    logic                 step_pend;

    logic [1:0]           sync;
    logic [DW-1:0]        deb_cnt;
    logic                 deb_level;
    logic                 deb_rise;

    logic [32+DISP_W-1:0] disp_ext;
    logic [32+DISP_W-1:0] disp_shift;

    // Level flips only after DEB_CYCLES consecutive samples that disagree with it.
    always_ff @(posedge clk50M) begin
        if (rst) begin
            sync      <= '0;
            deb_cnt   <= '0;
            deb_level <= 1'b0;
        end else begin
            sync <= {sync[0], step_btn};
            if (sync[1] == deb_level) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                deb_level <= sync[1];
                deb_cnt   <= '0;
            end else begin
                deb_cnt <= deb_cnt + DEB_ONE;
            end
        end
    end

    assign deb_rise = sync[1] && !deb_level && (deb_cnt == DEB_LAST);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        clk_nxt   = clk_cpu;
        pend_clr  = 1'b0;
        tick      = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_nxt = '0;
                clk_nxt = 1'b0;
                if (mode == MODE_RUN || step_pend) begin
                    state_nxt = HIGH;
                    clk_nxt   = 1'b1;
                    pend_clr  = 1'b1;
                    tick      = 1'b1;
                end
            end
            HIGH: begin
                if (cnt >= cpu_speed) begin
                    state_nxt = LOW;
                    clk_nxt   = 1'b0;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            LOW: begin
                if (cnt >= cpu_speed) begin
                    cnt_nxt = '0;
                    if (mode == MODE_RUN) begin
                        state_nxt = HIGH;
                        clk_nxt   = 1'b1;
                        tick      = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        clk_nxt   = 1'b0;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                clk_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk50M) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            clk_cpu   <= 1'b0;
            step_pend <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            clk_cpu <= clk_nxt;
            if (pend_clr) begin
                step_pend <= 1'b0;
            end else if (deb_rise && mode == MODE_STEP
                         && !step_pend && state == IDLE) begin
                step_pend <= 1'b1;
            end
        end
    end

    assign cpu_running = (state != IDLE);

    // Zero-extend so digits selected past bit 31 read as 0.
    assign disp_ext   = {{DISP_W{1'b0}}, monitor_data};
    assign disp_shift = disp_ext >> {disp_sel, 2'b00};

    always_ff @(posedge clk50M) begin
        if (rst) begin
            cpu_cycles <= '0;
            led_hb     <= '0;
            disp_data  <= '0;
        end else begin
            if (tick) begin
                cpu_cycles <= cpu_cycles + 32'd1;
                led_hb     <= {led_hb[LED_WIDTH-2:0], ~led_hb[LED_WIDTH-1]};
            end
            disp_data <= disp_shift[DISP_W-1:0];
        end
    end

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Bench for cpu_clk_ctrl: directed scenarios plus randomized traffic
// checked every cycle against a phase-timing reference model.
module tb_cpu_clk_ctrl;

    localparam int DEB = 4;

    logic        clk50M = 1'b0;
    logic        rst;
    logic [1:0]  mode;
    logic [31:0] cpu_speed;
    logic        step_btn;
    logic [31:0] monitor_data;
    logic [2:0]  disp_sel;
    logic        clk_cpu;
    logic        cpu_running;
    logic [31:0] cpu_cycles;
    logic [7:0]  led_hb;
    logic [7:0]  disp_data;

    int passed = 0;
    int total  = 0;

    always #5 clk50M = ~clk50M;

    cpu_clk_ctrl #(
        .CNT_WIDTH(32),
        .DEB_CYCLES(DEB),
        .NR_DIGIT(2),
        .LED_WIDTH(8)
    ) dut (
        .clk50M(clk50M),
        .rst(rst),
        .mode(mode),
        .cpu_speed(cpu_speed),
        .step_btn(step_btn),
        .monitor_data(monitor_data),
        .disp_sel(disp_sel),
        .clk_cpu(clk_cpu),
        .cpu_running(cpu_running),
        .cpu_cycles(cpu_cycles),
        .led_hb(led_hb),
        .disp_data(disp_data)
    );

    // Reference model: which phase the CPU clock is in and how long it has been there.
    int          m_ph = 0;
    longint      m_age = 0;
    bit          m_pend = 0;
    logic [31:0] m_cycles = 0;
    bit          m_lvl = 0;
    logic [7:0]  m_disp = 0;
    bit          q_sync[$] = '{0, 0};
    bit          hist[$];

    function automatic logic [7:0] johnson(input logic [31:0] n);
        int m;
        m = int'(n % 16);
        if (m <= 8) return 8'((1 << m) - 1);
        return 8'(8'hFF << (m - 8));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic model_edge();
        bit samp, all_eq, rise, old_pend;
        int old_ph;
        if (rst) begin
            m_ph = 0; m_age = 0; m_pend = 0; m_cycles = 0;
            m_lvl = 0; m_disp = 0;
            q_sync = '{0, 0};
            hist.delete();
            return;
        end
        q_sync.push_back(step_btn);
        samp = q_sync.pop_front();
        hist.push_back(samp);
        if (hist.size() > DEB) void'(hist.pop_front());
        rise = 0;
        if (hist.size() == DEB) begin
            all_eq = 1;
            foreach (hist[i]) if (hist[i] != samp) all_eq = 0;
            if (all_eq && samp != m_lvl) begin
                m_lvl = samp;
                rise  = samp;
            end
        end
        old_ph   = m_ph;
        old_pend = m_pend;
        if (old_ph == 0) begin
            if (mode == 2'b00 || old_pend) begin
                m_ph = 1; m_age = 0; m_pend = 0; m_cycles++;
            end
        end else if (m_age >= longint'(cpu_speed)) begin
            m_age = 0;
            if (old_ph == 1) m_ph = 2;
            else if (mode == 2'b00) begin
                m_ph = 1; m_cycles++;
            end else m_ph = 0;
        end else begin
            m_age++;
        end
        if (rise && mode == 2'b01 && !old_pend && old_ph == 0) m_pend = 1;
        m_disp = 8'({32'h0, monitor_data} >> (4 * disp_sel));
    endtask

    task automatic cycle();
        @(posedge clk50M);
        #1;
        model_edge();
        check("clk_cpu", 32'(clk_cpu), 32'(m_ph == 1));
        check("cpu_running", 32'(cpu_running), 32'(m_ph != 0));
        check("cpu_cycles", cpu_cycles, m_cycles);
        check("led_hb", 32'(led_hb), 32'(johnson(m_cycles)));
        check("disp_data", 32'(disp_data), 32'(m_disp));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        int highs, rises;
        bit prev;
        int runs[12] = '{1, 2, 3, 1, 2, 2, 3, 3, 1, 1, 3, 2};
        rst = 1'b1; mode = 2'b10; cpu_speed = 32'd3; step_btn = 1'b0;
        monitor_data = 32'h0; disp_sel = 3'd0;

        do_reset();
        check("rst_clk", 32'(clk_cpu), 32'd0);
        check("rst_cycles", cpu_cycles, 32'd0);
        check("rst_led", 32'(led_hb), 32'd0);
        check("rst_disp", 32'(disp_data), 32'd0);

        // Free run at speed 3: first rise one cycle after release, period 8.
        mode = 2'b00;
        cycle();
        check("run_first_rise", 32'(clk_cpu), 32'd1);
        for (int i = 1; i < 80; i++) begin
            cycle();
            check("run_wave", 32'(clk_cpu), 32'((i % 8) < 4));
        end
        check("run_cycles80", cpu_cycles, 32'd10);

        // Reset mid-phase forces clock low at once.
        rst = 1'b1;
        cycle();
        check("rst_mid", 32'(clk_cpu), 32'd0);
        rst = 1'b0;

        // Halt requested during HIGH: both phases complete, then idle.
        mode = 2'b10; cpu_speed = 32'd9;
        do_reset();
        mode = 2'b00;
        cycle();
        for (int off = 1; off <= 30; off++) begin
            if (off == 3) mode = 2'b10;
            cycle();
            check("halt_clk", 32'(clk_cpu), 32'(off < 10));
            check("halt_running", 32'(cpu_running), 32'(off < 20));
        end

        // Speed drops from 9 to 1 at cnt=5 of HIGH.
        mode = 2'b10; cpu_speed = 32'd9;
        do_reset();
        mode = 2'b00;
        cycle();
        for (int off = 1; off <= 12; off++) begin
            if (off == 6) cpu_speed = 32'd1;
            cycle();
            check("speed_chg", 32'(clk_cpu),
                  32'(off < 6 ? 1 : (((off - 6) / 2) % 2 == 1)));
        end

        // Single step from a clean 10-cycle press.
        mode = 2'b01; cpu_speed = 32'd1;
        do_reset();
        highs = 0; rises = 0; prev = 0;
        for (int i = 0; i < 40; i++) begin
            step_btn = (i < 10);
            cycle();
            if (clk_cpu) highs++;
            if (clk_cpu && !prev) rises++;
            prev = clk_cpu;
        end
        check("step_highs", 32'(highs), 32'd2);
        check("step_rises", 32'(rises), 32'd1);
        check("step_cycles", cpu_cycles, 32'd1);
        check("step_led", 32'(led_hb), 32'h01);

        // Bouncing button with runs shorter than the debounce window.
        do_reset();
        highs = 0;
        foreach (runs[r]) begin
            for (int k = 0; k < runs[r]; k++) begin
                step_btn = (r % 2 == 0);
                cycle();
                if (clk_cpu) highs++;
            end
        end
        step_btn = 1'b0;
        for (int i = 0; i < 15; i++) begin
            cycle();
            if (clk_cpu) highs++;
        end
        check("bounce_highs", 32'(highs), 32'd0);
        check("bounce_cycles", cpu_cycles, 32'd0);

        // Display nibble selection.
        monitor_data = 32'h89ABCDEF; disp_sel = 3'd0;
        cycle();
        check("disp_sel0", 32'(disp_data), 32'hEF);
        disp_sel = 3'd7;
        cycle();
        check("disp_sel7", 32'(disp_data), 32'h08);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 63) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 31) == 0) cpu_speed = $urandom_range(0, 6);
            if ($urandom_range(0, 5) == 0) step_btn = ~step_btn;
            monitor_data = $urandom;
            disp_sel = 3'($urandom_range(0, 7));
            rst = ($urandom_range(0, 399) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/cpu_clk_ctrl.md
CPU_CLK_CTRL -- requirements
Module: cpu_clk_ctrl

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 32, width of the half-period divider and cpu_speed.
REQ-002 SHALL have parameter DEB_CYCLES, default 50000, number of stable clk50M cycles required for step_btn debounce.
REQ-003 SHALL have parameter NR_DIGIT, default 2, number of 4-bit display nibbles output.
REQ-004 SHALL have parameter LED_WIDTH, default 8, heartbeat LED register width.
REQ-005 SHALL have port clk50M  input  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port mode  input  2  00 run, 01 single-step, 10 halt, 11 treated as halt.
REQ-008 SHALL have port cpu_speed  input  CNT_WIDTH  half-period length minus one, in clk50M cycles.
REQ-009 SHALL have port step_btn  input  1  raw asynchronous step button, active-high.
REQ-010 SHALL have port monitor_data  input  32  CPU debug word.
REQ-011 SHALL have port disp_sel  input  3  nibble index of the lowest displayed digit.
REQ-012 SHALL have port clk_cpu  output  1  generated CPU clock, registered.
REQ-013 SHALL have port cpu_running  output  1  high whenever FSM is not IDLE.
REQ-014 SHALL have port cpu_cycles  output  32  count of clk_cpu rising edges, wraps at 2^32.
REQ-015 SHALL have port led_hb  output  LED_WIDTH  heartbeat Johnson counter.
REQ-016 SHALL have port disp_data  output  4*NR_DIGIT  selected monitor nibbles, registered.

Function
REQ-017 SHALL implement FSM with states IDLE, HIGH, LOW and a divider counter cnt.
REQ-018 IDLE: clk_cpu=0, cnt held 0; if mode==00 or step_pend=1 -> HIGH with clk_cpu<=1, cnt<=0, step_pend<=0.
REQ-019 HIGH: cnt increments each cycle; when cnt>=cpu_speed -> LOW, clk_cpu<=0, cnt<=0.
REQ-020 LOW: cnt increments; when cnt>=cpu_speed -> HIGH (clk_cpu<=1, cnt<=0) if mode==00, else IDLE.
REQ-021 Each clk_cpu phase SHALL last exactly cpu_speed+1 cycles when cpu_speed is stable; cpu_speed=0 gives clk50M/2.
REQ-022 cpu_speed change mid-phase SHALL take effect immediately via >= compare; if new value <= cnt the phase ends next cycle; no phase ever shorter than 1 cycle.
REQ-023 Mode change SHALL never truncate a phase; halt/step entered during HIGH completes HIGH and LOW then goes IDLE.
REQ-024 step_btn SHALL pass a 2-flop synchronizer, then a debounce counter; debounced level changes only after DEB_CYCLES consecutive equal synchronized samples.
REQ-025 A debounced rising edge while mode==01 SHALL set step_pend; edges in other modes or while step_pend=1 or FSM not IDLE SHALL be ignored.
REQ-026 One step SHALL produce exactly one HIGH and one LOW phase, then IDLE.
REQ-027 cpu_cycles and led_hb SHALL update on the same cycle clk_cpu is set 1; led_hb <= {led_hb[LED_WIDTH-2:0], ~led_hb[LED_WIDTH-1]}.
REQ-028 disp_data SHALL register monitor_data[4*disp_sel +: 4*NR_DIGIT] each cycle, 1-cycle latency; nibbles beyond bit 31 SHALL read 0.
REQ-029 cpu_running SHALL be combinational from state (state != IDLE).

Reset
REQ-030 On rst=1 at a clock edge: state IDLE, clk_cpu 0, cnt 0, step_pend 0, debounce counter 0, debounced level 0, synchronizer 0, cpu_cycles 0, led_hb 0, disp_data 0.
REQ-031 Reset mid-phase SHALL force clk_cpu 0 on the next cycle; first rising edge after release with mode=00 occurs 1 cycle after rst deasserts.
REQ-032 rst SHALL take priority over all other inputs.

Verification
REQ-033 rst, mode=00, cpu_speed=3 -> clk_cpu period 8 cycles, 4 high/4 low; cpu_cycles=10 after 80 cycles from first rise.
REQ-034 mode=01, DEB_CYCLES=4, cpu_speed=1, step_btn high 10 cycles -> exactly one 2-high/2-low pulse, cpu_cycles +1, led_hb 00000000->00000001.
REQ-035 mode=01, step_btn bouncing with runs shorter than 4 cycles -> no clk_cpu pulse.
REQ-036 mode=00, cpu_speed=9, switch to mode=10 at cnt=2 of HIGH -> HIGH lasts 10, LOW 10, then IDLE, clk_cpu held 0, cpu_running 0.
REQ-037 cpu_speed 9->1 when cnt=5 in HIGH -> phase ends next cycle; next phases last 2 cycles.
REQ-038 monitor_data=32'h89ABCDEF, disp_sel=0 -> disp_data=8'hEF; disp_sel=7 -> 8'h08; both one cycle after change.
